// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: FSM state encoding, access-size
// encoding, default address width and the size-to-byte-count helper.
package mem_arbiter_pkg;

    localparam int AddrLen = 32;
    localparam int CntW    = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IF_RD  = 2'd1,
        MEM_RD = 2'd2,
        MEM_WR = 2'd3
    } arb_state_e;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10
    } mem_size_e;

    // The reserved encoding 2'b11 falls into the word case.
    function automatic logic [CntW-1:0] byte_count(input logic [1:0] size);
        logic [CntW-1:0] n;
        case (size)
            SIZE_BYTE: n = 3'd1;
            SIZE_HALF: n = 3'd2;
            default:   n = 3'd4;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mem_arbiter_byte_assembler.sv
// Packs bytes returned by the byte-wide RAM into a little-endian 32-bit word.
// clr_i zeroes the word so short loads come out zero-extended.
module byte_assembler
    import mem_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        cap_i,
    input  logic [1:0]  lane_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o
);

    logic [31:0] word_q;
    logic [31:0] word_d;

    always_comb begin
        word_d = word_q;
        if (clr_i) begin
            word_d = 32'h0;
        end else if (cap_i) begin
            case (lane_i)
                2'd0:    word_d[7:0]   = byte_i;
                2'd1:    word_d[15:8]  = byte_i;
                2'd2:    word_d[23:16] = byte_i;
                default: word_d[31:24] = byte_i;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q <= 32'h0;
        end else begin
            word_q <= word_d;
        end
    end

    assign word_o = word_q;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetches and load/stores onto a byte-wide RAM with
// one-cycle read latency. Optional MEM_ARB_IO_STALL_EN adds io_full_i back-pressure.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = AddrLen
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    input  logic              if_jump_i,
    output logic              if_ready_o,
    output logic [31:0]       if_data_o,
    output logic              if_busy_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [1:0]        mem_size_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [31:0]       mem_wdata_i,
    output logic              mem_ready_o,
    output logic [31:0]       mem_rdata_o,
`ifdef MEM_ARB_IO_STALL_EN
    input  logic              io_full_i,
`endif
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic              ram_wr_o,
    output logic [7:0]        ram_dout_o,
    input  logic [7:0]        ram_din_i
);

    arb_state_e        state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [CntW-1:0]   nbytes_q, nbytes_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic              ram_wr_q, ram_wr_d;
    logic [7:0]        ram_dout_q, ram_dout_d;
    logic              if_ready_q, if_ready_d;
    logic              mem_ready_q, mem_ready_d;

    logic              asm_clr;
    logic              asm_cap;
    logic [1:0]        asm_lane;
    logic [31:0]       asm_word;
    logic [ADDR_W-1:0] cur_addr;
    logic              wr_stall;

    assign cur_addr = base_q + ADDR_W'(cnt_q);

    // A store byte aimed at the IO segment waits while the IO queue is full.
`ifdef MEM_ARB_IO_STALL_EN
    logic [1:0] stall_seg;
    assign stall_seg = (state_q == IDLE) ? mem_addr_i[17:16] : cur_addr[17:16];
    assign wr_stall  = io_full_i && (stall_seg == 2'b11);
`else
    assign wr_stall  = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        nbytes_d    = nbytes_q;
        base_d      = base_q;
        wdata_d     = wdata_q;
        ram_addr_d  = ram_addr_q;
        ram_wr_d    = 1'b0;
        ram_dout_d  = ram_dout_q;
        if_ready_d  = 1'b0;
        mem_ready_d = 1'b0;
        asm_clr     = 1'b0;
        asm_cap     = 1'b0;
        asm_lane    = 2'(cnt_q - 3'd2);

        case (state_q)
            IDLE: begin
                if (mem_req_i) begin
                    base_d   = mem_addr_i;
                    nbytes_d = byte_count(mem_size_i);
                    wdata_d  = mem_wdata_i;
                    asm_clr  = 1'b1;
                    if (mem_we_i) begin
                        state_d = MEM_WR;
                        if (wr_stall) begin
                            cnt_d = '0;
                        end else begin
                            ram_addr_d = mem_addr_i;
                            ram_wr_d   = 1'b1;
                            ram_dout_d = mem_wdata_i[7:0];
                            cnt_d      = 3'd1;
                        end
                    end else begin
                        state_d    = MEM_RD;
                        ram_addr_d = mem_addr_i;
                        cnt_d      = 3'd1;
                    end
                end else if (if_req_i) begin
                    state_d    = IF_RD;
                    base_d     = if_addr_i;
                    nbytes_d   = 3'd4;
                    ram_addr_d = if_addr_i;
                    cnt_d      = 3'd1;
                    asm_clr    = 1'b1;
                end
            end

            // cnt_q counts edges since acceptance; byte k is captured two edges after its address.
            IF_RD, MEM_RD: begin
                if (state_q == IF_RD && if_jump_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    if (cnt_q < nbytes_q) begin
                        ram_addr_d = cur_addr;
                    end
                    if (cnt_q >= 3'd2) begin
                        asm_cap = 1'b1;
                    end
                    if (cnt_q == nbytes_q + 3'd1) begin
                        state_d     = IDLE;
                        cnt_d       = '0;
                        if_ready_d  = (state_q == IF_RD);
                        mem_ready_d = (state_q == MEM_RD);
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end

            // Here cnt_q counts bytes already written, so a stall simply holds it.
            MEM_WR: begin
                if (cnt_q == nbytes_q) begin
                    state_d     = IDLE;
                    cnt_d       = '0;
                    mem_ready_d = 1'b1;
                end else if (!wr_stall) begin
                    ram_addr_d = cur_addr;
                    ram_wr_d   = 1'b1;
                    ram_dout_d = wdata_q[8*cnt_q[1:0] +: 8];
                    cnt_d      = cnt_q + 3'd1;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            nbytes_q    <= '0;
            base_q      <= '0;
            wdata_q     <= '0;
            ram_addr_q  <= '0;
            ram_wr_q    <= 1'b0;
            ram_dout_q  <= '0;
            if_ready_q  <= 1'b0;
            mem_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            nbytes_q    <= nbytes_d;
            base_q      <= base_d;
            wdata_q     <= wdata_d;
            ram_addr_q  <= ram_addr_d;
            ram_wr_q    <= ram_wr_d;
            ram_dout_q  <= ram_dout_d;
            if_ready_q  <= if_ready_d;
            mem_ready_q <= mem_ready_d;
        end
    end

    byte_assembler u_asm (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (asm_clr),
        .cap_i  (asm_cap),
        .lane_i (asm_lane),
        .byte_i (ram_din_i),
        .word_o (asm_word)
    );

    assign if_ready_o  = if_ready_q;
    assign if_data_o   = asm_word;
    assign if_busy_o   = (state_q == IF_RD);
    assign mem_ready_o = mem_ready_q;
    assign mem_rdata_o = asm_word;
    assign ram_addr_o  = ram_addr_q;
    assign ram_wr_o    = ram_wr_q;
    assign ram_dout_o  = ram_dout_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a byte-wide, one-cycle-latency RAM model.
// Build with MEM_ARB_IO_STALL_EN to also exercise the IO store stall.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_jump;
    logic [31:0] if_addr;
    logic        if_ready, if_busy;
    logic [31:0] if_data;
    logic        mem_req, mem_we;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [31:0] ram_addr;
    logic        ram_wr;
    logic [7:0]  ram_dout;
    logic [7:0]  ram_din = 8'h00;
`ifdef MEM_ARB_IO_STALL_EN
    logic        io_full;
`endif

    logic [7:0]  ram [0:65535];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc;
    logic [7:0]  wr_bytes [4];

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .if_req_i    (if_req),
        .if_addr_i   (if_addr),
        .if_jump_i   (if_jump),
        .if_ready_o  (if_ready),
        .if_data_o   (if_data),
        .if_busy_o   (if_busy),
        .mem_req_i   (mem_req),
        .mem_we_i    (mem_we),
        .mem_size_i  (mem_size),
        .mem_addr_i  (mem_addr),
        .mem_wdata_i (mem_wdata),
        .mem_ready_o (mem_ready),
        .mem_rdata_o (mem_rdata),
`ifdef MEM_ARB_IO_STALL_EN
        .io_full_i   (io_full),
`endif
        .ram_addr_o  (ram_addr),
        .ram_wr_o    (ram_wr),
        .ram_dout_o  (ram_dout),
        .ram_din_i   (ram_din)
    );

    always @(posedge clk) begin
        ram_din <= ram[ram_addr[15:0]];
        if (ram_wr) ram[ram_addr[15:0]] <= ram_dout;
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input bit want_if, output int c);
        c = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if ((want_if ? if_ready : mem_ready) === 1'b1) begin
                c = i;
                break;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
        ram[16'h1000] = 8'h13; ram[16'h1001] = 8'h05;
        ram[16'h1002] = 8'h00; ram[16'h1003] = 8'h00;
        ram[16'h0003] = 8'hFF; ram[16'h0004] = 8'h77;
        wr_bytes[0] = 8'hEF; wr_bytes[1] = 8'hBE; wr_bytes[2] = 8'hAD; wr_bytes[3] = 8'hDE;

        rst = 1'b1; if_req = 0; if_jump = 0; if_addr = 0;
        mem_req = 0; mem_we = 0; mem_size = 0; mem_addr = 0; mem_wdata = 0;
`ifdef MEM_ARB_IO_STALL_EN
        io_full = 0;
`endif
        tick(); tick();
        chk("rst_busy",  {63'd0, if_busy},   64'd0);
        chk("rst_ready", {62'd0, if_ready, mem_ready}, 64'd0);
        chk("rst_wr",    {63'd0, ram_wr},    64'd0);
        chk("rst_addr",  {32'd0, ram_addr},  64'd0);
        chk("rst_data",  {32'd0, if_data},   64'd0);

        // Fetch 0x1000 accepted at the first edge after reset release.
        rst = 1'b0; if_req = 1; if_addr = 32'h1000;
        tick();
        chk("if_busy",   {63'd0, if_busy},  64'd1);
        chk("if_addr0",  {32'd0, ram_addr}, 64'h1000);
        wait_ready(1'b1, cyc);
        chk("if_lat",    64'(cyc), 64'd5);
        chk("if_data",   {32'd0, if_data},  64'h513);
        chk("if_idle",   {63'd0, if_busy},  64'd0);
        if_req = 0;
        tick();
        chk("if_pulse",  {63'd0, if_ready}, 64'd0);

        // Store word with a simultaneous fetch: MEM wins, fetch follows without a bubble.
        mem_req = 1; mem_we = 1; mem_size = 2'b10; mem_addr = 32'h2000; mem_wdata = 32'hDEADBEEF;
        if_req = 1; if_addr = 32'h1000;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("st_wr",   {63'd0, ram_wr},   64'd1);
            chk("st_addr", {32'd0, ram_addr}, 64'(32'h2000 + k));
            chk("st_byte", {56'd0, ram_dout}, {56'd0, wr_bytes[k]});
            chk("st_nofetch", {63'd0, if_busy}, 64'd0);
        end
        tick();
        chk("st_ready",  {63'd0, mem_ready}, 64'd1);
        chk("st_wr_off", {63'd0, ram_wr},    64'd0);
        mem_req = 0;
        tick();
        chk("st_then_if", {63'd0, if_busy}, 64'd1);
        chk("st_if_addr", {32'd0, ram_addr}, 64'h1000);
        wait_ready(1'b1, cyc);
        chk("st_if_lat",  64'(cyc), 64'd5);
        if_req = 0;
        chk("st_mem", {32'd0, ram[16'h2003], ram[16'h2002], ram[16'h2001], ram[16'h2000]}, 64'hDEADBEEF);

        // Load byte @0x3: one address, zero-extended result.
        tick();
        mem_req = 1; mem_we = 0; mem_size = 2'b00; mem_addr = 32'h3;
        tick();
        chk("lb_addr", {32'd0, ram_addr}, 64'h3);
        wait_ready(1'b0, cyc);
        chk("lb_lat",   64'(cyc), 64'd2);
        chk("lb_data",  {32'd0, mem_rdata}, 64'hFF);
        chk("lb_1addr", {32'd0, ram_addr},  64'h3);
        mem_req = 0;
        tick();

        // Load half @0x2000 and size 2'b11 (treated as word).
        mem_req = 1; mem_size = 2'b01; mem_addr = 32'h2000;
        tick();
        wait_ready(1'b0, cyc);
        chk("lh_lat",  64'(cyc), 64'd3);
        chk("lh_data", {32'd0, mem_rdata}, 64'hBEEF);
        mem_size = 2'b11;
        tick();
        wait_ready(1'b0, cyc);
        chk("l11_lat",  64'(cyc), 64'd5);
        chk("l11_data", {32'd0, mem_rdata}, 64'hDEADBEEF);
        mem_req = 0;
        tick();

        // Jump after the second fetch byte aborts, then the new PC is fetched.
        if_req = 1; if_addr = 32'h1000;
        tick();
        tick();
        chk("jmp_addr1", {32'd0, ram_addr}, 64'h1001);
        if_jump = 1; if_addr = 32'h2000;
        tick();
        chk("jmp_idle",  {63'd0, if_busy},  64'd0);
        chk("jmp_noadr", {32'd0, ram_addr}, 64'h1001);
        chk("jmp_nordy", {63'd0, if_ready}, 64'd0);
        tick();
        chk("jmp_new",   {63'd0, if_busy},  64'd1);
        chk("jmp_naddr", {32'd0, ram_addr}, 64'h2000);
        if_jump = 0;
        wait_ready(1'b1, cyc);
        chk("jmp_lat",  64'(cyc), 64'd5);
        chk("jmp_data", {32'd0, if_data}, 64'hDEADBEEF);
        if_req = 0;
        tick();

        // Reset in the middle of a word store.
        mem_req = 1; mem_we = 1; mem_size = 2'b10; mem_addr = 32'h4000; mem_wdata = 32'h11223344;
        tick(); tick(); tick();
        chk("rw_wr_before", {63'd0, ram_wr}, 64'd1);
        rst = 1'b1; mem_req = 0;
        #1;
        chk("rw_wr_now", {63'd0, ram_wr},   64'd0);
        chk("rw_addr",   {32'd0, ram_addr}, 64'd0);
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rw_quiet", {62'd0, ram_wr, mem_ready}, 64'd0);
        end
        chk("rw_mem", {32'd0, ram[16'h4003], ram[16'h4002], ram[16'h4001], ram[16'h4000]}, 64'h00003344);

`ifdef MEM_ARB_IO_STALL_EN
        // Store byte to the IO segment with io_full high for three edges.
        mem_req = 1; mem_we = 1; mem_size = 2'b00; mem_addr = 32'h30000; mem_wdata = 32'hA5;
        io_full = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("io_hold", {63'd0, ram_wr}, 64'd0);
        end
        io_full = 0;
        tick();
        chk("io_wr",   {63'd0, ram_wr},   64'd1);
        chk("io_addr", {32'd0, ram_addr}, 64'h30000);
        chk("io_byte", {56'd0, ram_dout}, 64'hA5);
        tick();
        chk("io_ready", {63'd0, mem_ready}, 64'd1);
        chk("io_wroff", {63'd0, ram_wr},    64'd0);
        mem_req = 0;
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning address width of all address ports.
REQ-002 SHALL have ports: clk  in  1  system clock; rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports: if_req_i  in  1  fetch request; if_addr_i  in  ADDR_W  fetch byte address; if_jump_i  in  1  cancel in-flight fetch.
REQ-004 SHALL have ports: if_ready_o  out  1  fetch-complete pulse; if_data_o  out  32  fetched word; if_busy_o  out  1  arbiter serving IF.
REQ-005 SHALL have ports: mem_req_i  in  1  load/store request; mem_we_i  in  1  1=store; mem_size_i  in  2  00=byte, 01=half, 10=word; mem_addr_i  in  ADDR_W; mem_wdata_i  in  32.
REQ-006 SHALL have ports: mem_ready_o  out  1  load/store-complete pulse; mem_rdata_o  out  32  zero-extended load data.
REQ-007 SHALL have ports: ram_addr_o  out  ADDR_W; ram_wr_o  out  1  byte write strobe; ram_dout_o  out  8; ram_din_i  in  8  (RAM read latency 1 cycle).

Function
REQ-010 SHALL implement states IDLE, IF_RD, MEM_RD, MEM_WR.
REQ-011 IDLE SHALL accept at a clock edge: mem_req_i first (MEM priority), else if_req_i; MEM_RD/MEM_WR by mem_we_i; IF_RD always 4 bytes.
REQ-012 Byte count n SHALL be 1/2/4 for mem_size_i 00/01/10; 11 SHALL be treated as 10.
REQ-013 SHALL issue byte k (k=0..n-1) with ram_addr_o = base+k, registered, in the cycle after acceptance edge T0+k; little-endian.
REQ-014 Read: byte k SHALL be captured from ram_din_i at edge T0+k+2; if_ready_o/mem_ready_o SHALL be high for exactly the one cycle after edge T0+n+1, data valid that cycle.
REQ-015 Write: ram_wr_o SHALL be high with ram_dout_o = mem_wdata_i[8k+7:8k] for byte k cycles only; mem_ready_o high for one cycle after edge T0+n.
REQ-016 The state SHALL be IDLE during the ready cycle; a new request SHALL be accepted at the edge ending that cycle (no bubble).
REQ-017 No preemption: a request arriving mid-transaction SHALL wait; requesters SHALL hold req/addr/data stable until ready.
REQ-018 if_jump_i high in IF_RD SHALL abort at the next edge: IDLE, no if_ready_o, no further RAM address for that fetch; ignored in other states.
REQ-019 if_jump_i and if_req_i together in IDLE SHALL accept the fetch (new PC).
REQ-020 if_busy_o SHALL equal (state==IF_RD).
REQ-021 ram_wr_o SHALL be 0 in IDLE, IF_RD, MEM_RD; ram_addr_o SHALL hold its last value when idle.
REQ-022 mem_rdata_o upper bytes SHALL be zero for n<4; sign extension belongs to MEM stage.

Reset
REQ-030 rst SHALL force IDLE, counters 0, all outputs 0 immediately, including mid-transaction; no partial-write completion after release.
REQ-031 First acceptance SHALL occur at the first edge after rst deasserts.

Configuration
REQ-040 MEM_ARB_IO_STALL_EN defined: SHALL add input io_full_i (1); a store byte with addr[17:16]==2'b11 SHALL not be issued (ram_wr_o=0, counter held) while io_full_i high.
REQ-041 MEM_ARB_IO_STALL_EN undefined: port absent, stores never stall.

Structure
REQ-050 State encoding, size encoding and AddrLen SHALL live in the shared defines header.
REQ-051 One sub-module byte_assembler SHALL perform byte-lane capture/packing; the FSM and counters remain in mem_arbiter.

Verification
REQ-060 IF fetch 0x1000, RAM bytes 13,05,00,00 -> if_ready_o one cycle after edge T0+5, if_data_o=0x00000513.
REQ-061 mem_req_i store word 0xDEADBEEF @0x2000 with if_req_i simultaneous -> 4 ram_wr_o bytes EF,BE,AD,DE @0x2000..0x2003, then fetch starts at the edge ending the mem_ready_o cycle.
REQ-062 Load byte @0x3 returning 0xFF -> mem_rdata_o=0x000000FF, one RAM address issued.
REQ-063 if_jump_i high after 2nd byte of fetch -> no if_ready_o, IDLE next cycle, new fetch @0x2000 accepted.
REQ-064 rst asserted after 2nd write byte -> ram_wr_o=0 immediately, no further writes after release.
REQ-065 MEM_ARB_IO_STALL_EN: store byte @0x30000 with io_full_i high 3 cycles -> ram_wr_o held 0 3 cycles, then one write, mem_ready_o next cycle.
